// File: rtl/spi_pkg.sv
// spi_pkg: frame layout, register map and controller state encoding shared with spi_peripheral
package spi_pkg;
  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_RW_BIT = 15;
  localparam int SPI_ADDR_MSB = 14;
  localparam int SPI_ADDR_LSB = 8;
  localparam int SPI_DATA_MSB = 7;
  localparam int SPI_DATA_LSB = 0;
  localparam logic SPI_RW_WRITE = 1'b1;
  localparam logic [6:0] EN_REG_OUT_7_0 = 7'd0;
  localparam logic [6:0] EN_REG_OUT_15_8 = 7'd1;
  localparam logic [6:0] EN_REG_PWM_7_0 = 7'd2;
  localparam logic [6:0] EN_REG_PWM_15_8 = 7'd3;
  localparam logic [6:0] PWM_DUTY_CYCLE = 7'd4;
  localparam logic [6:0] SPI_MAX_ADDRESS = 7'd4;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} spi_ctrl_state_t;
  function automatic int spi_max(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter whose terminal flag marks the last cycle of a phase
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator sending one 16-bit register-write frame per command
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi
);
  localparam int PW = $clog2(spi_max(CLK_DIV, CS_GAP) + 1);
  spi_ctrl_state_t state, nxt;
  logic [SPI_FRAME_BITS-1:0] sh;
  logic [4:0] bits_sent;
  logic tc, accept;
  logic [PW-1:0] load_val;
  assign accept = cmd_valid && state == IDLE;
  assign load_val = nxt == GAP ? PW'(CS_GAP - 1) : PW'(CLK_DIV - 1);
  spi_phase_timer #(.W(PW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(nxt != state),
    .value(load_val),
    .tc(tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? SETUP : IDLE;
      SETUP:   nxt = tc ? HIGH : SETUP;
      HIGH:    nxt = tc ? (bits_sent == 5'd16 ? HOLD : LOW) : HIGH;
      LOW:     nxt = tc ? HIGH : LOW;
      HOLD:    nxt = tc ? GAP : HOLD;
      GAP:     nxt = tc ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spi_cs <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cmd_ready <= 1'b1;
      sh <= '0;
      bits_sent <= '0;
    end else begin
      spi_cs <= nxt == IDLE || nxt == GAP;
      spi_sclk <= nxt == HIGH;
      busy <= nxt != IDLE;
      done <= state == GAP && nxt == IDLE;
      cmd_ready <= nxt == IDLE;
      if (accept) begin
        sh <= {cmd_write, cmd_addr, cmd_data};
        spi_mosi <= cmd_write;
        bits_sent <= '0;
      end else if (state == HIGH && nxt == LOW) begin
        sh <= sh << 1;
        spi_mosi <= sh[SPI_FRAME_BITS-2];
      end else if (nxt == GAP) spi_mosi <= 1'b0;
      if (state != HIGH && nxt == HIGH && bits_sent != 5'd16) bits_sent <= bits_sent + 1'b1;
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: randomized frame checks of spi_controller against a bench-side register model
module tb_spi_controller;
  import spi_pkg::*;
  localparam int CD = 4;
  localparam int CG = 4;
  localparam int FD = 2;
  localparam int FG = 2;
  localparam int LAT = 33 * CD + CG + 1;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_write = 0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic cmd_ready, busy, done, cs, sclk, mosi;
  logic f_valid = 0, f_write = 0;
  logic [6:0] f_addr = '0;
  logic [7:0] f_data = '0;
  logic f_ready, f_busy, f_done, f_cs, f_sclk, f_mosi;
  int total = 0, bad = 0;
  int m_rises = 0, m_low = 0, hi_cnt = 0, last_hi = 0, since_mosi = 0, since_rise = 0;
  int viol = 0, done_cnt = 0, frames = 0;
  logic [15:0] m_bits = '0;
  logic p_cs = 1, p_sclk = 0, p_mosi = 0, p_done = 0, p_rst = 0;
  int f_rises = 0, f_low = 0;
  logic [15:0] f_bits = '0;
  logic fp_cs = 1, fp_sclk = 0, fp_rst = 0;
  logic [15:0] obs_frm[$], exp_frm[$], f_frm[$];
  int obs_rise[$], obs_low[$], f_rise_q[$], f_low_q[$];
  logic [7:0] mdl[5] = '{default: 8'h00};
  logic [7:0] dec[5] = '{default: 8'h00};
  always #5 clk = ~clk;
  spi_controller u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .busy(busy), .done(done), .spi_cs(cs), .spi_sclk(sclk), .spi_mosi(mosi)
  );
  spi_controller #(.CLK_DIV(FD), .CS_GAP(FG)) u_fast (
    .clk(clk), .rst_n(rst_n), .cmd_valid(f_valid), .cmd_ready(f_ready),
    .cmd_write(f_write), .cmd_addr(f_addr), .cmd_data(f_data),
    .busy(f_busy), .done(f_done), .spi_cs(f_cs), .spi_sclk(f_sclk), .spi_mosi(f_mosi)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && p_rst) begin
      if (cs != p_cs && p_sclk) viol++;
      if (cs && p_cs && sclk != p_sclk) viol++;
      if (done && p_done) viol++;
    end
    if (done) done_cnt++;
    if (cs) begin
      if (!p_cs) begin
        obs_frm.push_back(m_bits);
        obs_rise.push_back(m_rises);
        obs_low.push_back(m_low);
        hi_cnt = 0;
      end
      hi_cnt++;
    end else begin
      if (p_cs) begin
        last_hi = hi_cnt;
        m_rises = 0;
        m_low = 0;
        m_bits = '0;
        since_mosi = 0;
        since_rise = 1000;
      end
      m_low++;
      since_rise++;
      if (!p_cs && mosi != p_mosi) begin
        chk("mosi_hold", since_rise >= CD, 1);
        since_mosi = 0;
      end else since_mosi++;
      if (sclk && !p_sclk) begin
        chk("mosi_setup", since_mosi >= CD, 1);
        m_rises++;
        m_bits = {m_bits[14:0], mosi};
        since_rise = 0;
      end
    end
    p_cs = cs;
    p_sclk = sclk;
    p_mosi = mosi;
    p_done = done;
    p_rst = rst_n;
  end
  always @(negedge clk) begin
    if (rst_n && fp_rst) begin
      if (f_cs != fp_cs && fp_sclk) viol++;
      if (f_cs && fp_cs && f_sclk != fp_sclk) viol++;
    end
    if (f_cs && !fp_cs) begin
      f_frm.push_back(f_bits);
      f_rise_q.push_back(f_rises);
      f_low_q.push_back(f_low);
    end
    if (!f_cs) begin
      if (fp_cs) begin
        f_rises = 0;
        f_low = 0;
        f_bits = '0;
      end
      f_low++;
      if (f_sclk && !fp_sclk) begin
        f_rises++;
        f_bits = {f_bits[14:0], f_mosi};
      end
    end
    fp_cs = f_cs;
    fp_sclk = f_sclk;
    fp_rst = rst_n;
  end
  task automatic push_cmd(input logic w, input logic [6:0] a, input logic [7:0] d);
    exp_frm.push_back({w, a, d});
    if (w == SPI_RW_WRITE && a <= SPI_MAX_ADDRESS) mdl[a[2:0]] = d;
  endtask
  task automatic wait_accept();
    int n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 400, 1);
    @(negedge clk);
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic check_frame();
    logic [15:0] f, e;
    if (obs_frm.size() == 0 || exp_frm.size() == 0) begin
      chk("frame_present", 0, 1);
      return;
    end
    f = obs_frm.pop_front();
    e = exp_frm.pop_front();
    chk("frame", f, e);
    chk("rises", obs_rise.pop_front(), 16);
    chk("cs_low", obs_low.pop_front(), 33 * CD);
    if (f[15] && f[14:8] <= SPI_MAX_ADDRESS) dec[f[10:8]] = f[7:0];
    frames++;
  endtask
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
    int lat;
    cmd_valid = 1;
    cmd_write = w;
    cmd_addr = a;
    cmd_data = d;
    push_cmd(w, a, d);
    wait_accept();
    cmd_valid = 0;
    {cmd_write, cmd_addr, cmd_data} = 16'($urandom);
    chk("busy", busy, 1);
    wait_done(lat);
    chk("latency", lat, LAT);
    check_frame();
  endtask
  task automatic b2b(input logic [6:0] a1, input logic [7:0] d1, input logic [6:0] a2, input logic [7:0] d2);
    int lat;
    cmd_valid = 1;
    cmd_write = 1;
    cmd_addr = a1;
    cmd_data = d1;
    push_cmd(1, a1, d1);
    wait_accept();
    cmd_addr = a2;
    cmd_data = d2;
    push_cmd(1, a2, d2);
    wait_done(lat);
    chk("b2b_lat1", lat, LAT);
    chk("b2b_ready", cmd_ready, 1);
    check_frame();
    @(negedge clk);
    cmd_valid = 0;
    {cmd_write, cmd_addr, cmd_data} = 16'($urandom);
    chk("b2b_busy", busy, 1);
    wait_done(lat);
    chk("b2b_lat2", lat, LAT);
    check_frame();
    chk("cs_gap", last_hi, CG + 1);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n, lat, d0;
    logic [15:0] fexp;
    logic [6:0] a;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1;
    @(negedge clk);
    send(1, EN_REG_OUT_7_0, 8'hA5);
    chk("reg0_a5", dec[0], 8'hA5);
    send(0, EN_REG_OUT_15_8, 8'hFF);
    chk("read_no_write", dec[1], 8'h00);
    send(1, PWM_DUTY_CYCLE, 8'h80);
    send(1, EN_REG_PWM_7_0, 8'h0F);
    chk("duty_80", dec[4], 8'h80);
    chk("pwm_lo_0f", dec[2], 8'h0F);
    chk("pwm_hi_0", dec[3], 8'h00);
    b2b(EN_REG_OUT_15_8, 8'h5A, EN_REG_PWM_15_8, 8'hC3);
    chk("b2b_r1", dec[1], 8'h5A);
    chk("b2b_r3", dec[3], 8'hC3);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 3) == 0 ? 7'($urandom) : 7'($urandom_range(0, 4));
      send(1'($urandom_range(0, 1)), a, 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    cmd_valid = 1;
    cmd_write = 1;
    cmd_addr = EN_REG_OUT_7_0;
    cmd_data = 8'h77;
    wait_accept();
    cmd_valid = 0;
    n = 0;
    while (m_rises != 7 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rise7_timeout", n < 2000, 1);
    d0 = done_cnt;
    rst_n = 0;
    #1;
    chk("abort_cs", cs, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    if (obs_rise.size() != 0) begin
      chk("abort_rises", obs_rise.pop_front(), 7);
      void'(obs_frm.pop_front());
      void'(obs_low.pop_front());
    end else chk("abort_frame_seen", 0, 1);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_reg0", dec[0], mdl[0]);
    send(1, EN_REG_PWM_15_8, 8'h3C);
    chk("pwm_hi_3c", dec[3], 8'h3C);
    chk("f_ready", f_ready, 1);
    f_valid = 1;
    f_write = 1;
    f_addr = 7'h7F;
    f_data = 8'($urandom);
    fexp = {f_write, f_addr, f_data};
    @(negedge clk);
    f_valid = 0;
    f_data = ~f_data;
    chk("f_busy", f_busy, 1);
    lat = 1;
    while (!f_done && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("f_latency", lat, 33 * FD + FG + 1);
    if (f_frm.size() != 0) begin
      chk("f_frame", f_frm.pop_front(), fexp);
      chk("f_rises", f_rise_q.pop_front(), 16);
      chk("f_cs_low", f_low_q.pop_front(), 33 * FD);
    end else chk("f_frame_seen", 0, 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) chk($sformatf("reg%0d", i), dec[i], mdl[i]);
    chk("protocol", viol, 0);
    chk("done_count", done_cnt, frames);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
